// File: rtl/mem2_sub1_pkg.sv
// rtl/mem2_sub1_pkg.sv - bus widths and field layout for the slot-1 mem2 stage
package mem2_sub1_pkg;

    localparam int BUS1_WD = 75;

    typedef struct packed {
        logic        first;
        logic [3:0]  rf_wen;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] result;
        logic [31:0] pc;
    } slot1_bus_t;

    // A cancelled slot-1 instruction keeps flowing but must not write anything.
    function automatic slot1_bus_t cancel_gate(slot1_bus_t b, logic cancel);
        slot1_bus_t r;
        r = b;
        if (cancel) begin
            r.rf_wen = 4'b0;
            r.gr_we  = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/mem2_sub1_ctrl.sv
// rtl/mem2_sub1_ctrl.sv - valid/allowin handshake register for one pipeline stage
module mem2_sub1_ctrl (
    input  logic clk,
    input  logic resetn,
    input  logic in_valid_i,
    input  logic ready_go_i,
    input  logic out_allowin_i,
    input  logic flush_i,
    output logic valid_o,
    output logic allowin_o,
    output logic to_out_valid_o,
    output logic load_o
);
    logic valid_q, valid_d;

    assign allowin_o      = !valid_q || (ready_go_i && out_allowin_i);
    assign to_out_valid_o = valid_q && ready_go_i && !flush_i;
    assign load_o         = in_valid_i && allowin_o;
    assign valid_o        = valid_q;

    always_comb begin
        valid_d = valid_q;
        if (flush_i)
            valid_d = 1'b0;
        else if (allowin_o)
            valid_d = in_valid_i;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            valid_q <= 1'b0;
        else
            valid_q <= valid_d;
    end

endmodule

// File: rtl/mem2_sub1.sv
// rtl/mem2_sub1.sv - slot-1 mem2 stage: registers the mem1 bus, applies flush/cancel, feeds writeback
module mem2_sub1
    import mem2_sub1_pkg::*;
#(
    parameter int M1S_TO_M2S_BUS1_WD = BUS1_WD,
    parameter int M2S_TO_WS_BUS1_WD  = BUS1_WD
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          m1s_to_m2s_valid,
    input  logic [M1S_TO_M2S_BUS1_WD-1:0] m1s_to_m2s_bus,
    output logic                          m2s_allowin,
    input  logic                          pair_ready_go,
    input  logic                          ws_allowin,
    output logic                          m2s_to_ws_valid,
    output logic [M2S_TO_WS_BUS1_WD-1:0]  m2s_to_ws_bus,
    input  logic                          flush,
    input  logic                          pair_cancel,
    output logic [4:0]                    m2s_rd,
    output logic [31:0]                   m2s_result,
    output logic                          m2s_reg_write,
    output logic [31:0]                   m2s_retired
);
    logic       m2s_valid;
    logic       load;
    logic       cancelled;
    slot1_bus_t bus_q, bus_d;
    slot1_bus_t out_bus;
    logic [31:0] retired_q, retired_d;

    mem2_sub1_ctrl u_ctrl (
        .clk            (clk),
        .resetn         (resetn),
        .in_valid_i     (m1s_to_m2s_valid),
        .ready_go_i     (pair_ready_go),
        .out_allowin_i  (ws_allowin),
        .flush_i        (flush),
        .valid_o        (m2s_valid),
        .allowin_o      (m2s_allowin),
        .to_out_valid_o (m2s_to_ws_valid),
        .load_o         (load)
    );

    // Slot 0 excepting only kills us when we are the younger half of the pair.
    assign cancelled = m2s_valid && pair_cancel && !bus_q.first;

    always_comb begin
        bus_d = bus_q;
        if (load)
            bus_d = slot1_bus_t'(m1s_to_m2s_bus);
    end

    always_comb begin
        retired_d = retired_q;
        if (m2s_to_ws_valid && ws_allowin && !cancelled)
            retired_d = retired_q + 32'd1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bus_q     <= '0;
            retired_q <= 32'd0;
        end else begin
            bus_q     <= bus_d;
            retired_q <= retired_d;
        end
    end

    assign out_bus       = cancel_gate(bus_q, cancelled);
    assign m2s_to_ws_bus = out_bus;
    assign m2s_rd        = bus_q.dest;
    assign m2s_result    = bus_q.result;
    assign m2s_reg_write = m2s_valid && bus_q.gr_we && !cancelled;
    assign m2s_retired   = retired_q;

endmodule

// File: tb/tb_mem2_sub1.sv
// tb/tb_mem2_sub1.sv - directed self-checking bench for mem2_sub1
module tb_mem2_sub1;
    logic        clk = 1'b0;
    logic        resetn;
    logic        m1s_to_m2s_valid;
    logic [74:0] m1s_to_m2s_bus;
    logic        m2s_allowin;
    logic        pair_ready_go;
    logic        ws_allowin;
    logic        m2s_to_ws_valid;
    logic [74:0] m2s_to_ws_bus;
    logic        flush;
    logic        pair_cancel;
    logic [4:0]  m2s_rd;
    logic [31:0] m2s_result;
    logic        m2s_reg_write;
    logic [31:0] m2s_retired;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] exp_ret = 32'd0;

    always #5 clk = ~clk;

    mem2_sub1 dut (
        .clk              (clk),
        .resetn           (resetn),
        .m1s_to_m2s_valid (m1s_to_m2s_valid),
        .m1s_to_m2s_bus   (m1s_to_m2s_bus),
        .m2s_allowin      (m2s_allowin),
        .pair_ready_go    (pair_ready_go),
        .ws_allowin       (ws_allowin),
        .m2s_to_ws_valid  (m2s_to_ws_valid),
        .m2s_to_ws_bus    (m2s_to_ws_bus),
        .flush            (flush),
        .pair_cancel      (pair_cancel),
        .m2s_rd           (m2s_rd),
        .m2s_result       (m2s_result),
        .m2s_reg_write    (m2s_reg_write),
        .m2s_retired      (m2s_retired)
    );

    function automatic logic [74:0] mk(input logic first, input logic [3:0] wen, input logic gwe,
                                       input logic [4:0] dest, input logic [31:0] res, input logic [31:0] pc);
        return {first, wen, gwe, dest, res, pc};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0; m1s_to_m2s_valid = 1'b0; m1s_to_m2s_bus = '0;
        pair_ready_go = 1'b1; ws_allowin = 1'b1; flush = 1'b0; pair_cancel = 1'b0;
        tick(); tick();
        n_cmp++; if (m2s_allowin !== 1'b1) begin n_bad++; $display("FAIL reset_allowin got %b want 1", m2s_allowin); end
        n_cmp++; if (m2s_to_ws_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", m2s_to_ws_valid); end
        n_cmp++; if (m2s_retired !== 32'd0) begin n_bad++; $display("FAIL reset_retired got %h want 0", m2s_retired); end
        n_cmp++; if (m2s_to_ws_bus !== 75'd0) begin n_bad++; $display("FAIL reset_bus got %h want 0", m2s_to_ws_bus); end
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_single();
        logic [74:0] a;
        a = mk(1'b0, 4'hF, 1'b1, 5'd5, 32'h1234, 32'hBFC00010);
        m1s_to_m2s_valid = 1'b1; m1s_to_m2s_bus = a;
        tick();
        m1s_to_m2s_valid = 1'b0; m1s_to_m2s_bus = '0;
        #1;
        n_cmp++; if (m2s_to_ws_valid !== 1'b1) begin n_bad++; $display("FAIL single_valid got %b want 1", m2s_to_ws_valid); end
        n_cmp++; if (m2s_to_ws_bus !== a) begin n_bad++; $display("FAIL single_bus got %h want %h", m2s_to_ws_bus, a); end
        n_cmp++; if (m2s_reg_write !== 1'b1) begin n_bad++; $display("FAIL single_regwrite got %b want 1", m2s_reg_write); end
        n_cmp++; if (m2s_rd !== 5'd5) begin n_bad++; $display("FAIL single_rd got %0d want 5", m2s_rd); end
        n_cmp++; if (m2s_result !== 32'h1234) begin n_bad++; $display("FAIL single_result got %h want 1234", m2s_result); end
        tick();
        exp_ret = exp_ret + 1;
        n_cmp++; if (m2s_retired !== 32'd1) begin n_bad++; $display("FAIL single_retired got %0d want 1", m2s_retired); end
        n_cmp++; if (m2s_to_ws_valid !== 1'b0) begin n_bad++; $display("FAIL single_drain got %b want 0", m2s_to_ws_valid); end
    endtask

    task automatic test_back_to_back();
        logic [74:0] b [4];
        for (int i = 0; i < 4; i++)
            b[i] = mk(i[0], 4'h3, 1'b1, 5'(i + 8), 32'hA000 + 32'(i), 32'h8000_0000 + 32'(4 * i));
        for (int i = 0; i <= 4; i++) begin
            if (i < 4) begin m1s_to_m2s_valid = 1'b1; m1s_to_m2s_bus = b[i]; end
            else begin m1s_to_m2s_valid = 1'b0; m1s_to_m2s_bus = '0; end
            #1;
            n_cmp++; if (m2s_allowin !== 1'b1) begin n_bad++; $display("FAIL b2b_allowin[%0d] got %b want 1", i, m2s_allowin); end
            if (i > 0) begin
                n_cmp++; if (m2s_to_ws_valid !== 1'b1 || m2s_to_ws_bus !== b[i-1]) begin
                    n_bad++; $display("FAIL b2b_out[%0d] got %b/%h want 1/%h", i, m2s_to_ws_valid, m2s_to_ws_bus, b[i-1]);
                end
            end
            tick();
        end
        exp_ret = exp_ret + 4;
        n_cmp++; if (m2s_retired !== exp_ret) begin n_bad++; $display("FAIL b2b_retired got %0d want %0d", m2s_retired, exp_ret); end
    endtask

    task automatic test_stall();
        logic [74:0] c, d;
        c = mk(1'b1, 4'h1, 1'b1, 5'd12, 32'hCCCC_0001, 32'h0000_0100);
        d = mk(1'b0, 4'h2, 1'b1, 5'd13, 32'hDDDD_0002, 32'h0000_0104);
        m1s_to_m2s_valid = 1'b1; m1s_to_m2s_bus = c;
        tick();
        m1s_to_m2s_bus = d; ws_allowin = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++; if (m2s_allowin !== 1'b0) begin n_bad++; $display("FAIL stall_allowin[%0d] got %b want 0", i, m2s_allowin); end
            n_cmp++; if (m2s_to_ws_bus !== c) begin n_bad++; $display("FAIL stall_hold[%0d] got %h want %h", i, m2s_to_ws_bus, c); end
            tick();
        end
        ws_allowin = 1'b1;
        #1;
        n_cmp++; if (m2s_allowin !== 1'b1 || m2s_to_ws_bus !== c) begin
            n_bad++; $display("FAIL stall_release got %b/%h want 1/%h", m2s_allowin, m2s_to_ws_bus, c);
        end
        tick();
        m1s_to_m2s_valid = 1'b0; m1s_to_m2s_bus = '0;
        #1;
        n_cmp++; if (m2s_to_ws_valid !== 1'b1 || m2s_to_ws_bus !== d) begin
            n_bad++; $display("FAIL stall_next got %b/%h want 1/%h", m2s_to_ws_valid, m2s_to_ws_bus, d);
        end
        tick();
        exp_ret = exp_ret + 2;
        n_cmp++; if (m2s_retired !== exp_ret) begin n_bad++; $display("FAIL stall_retired got %0d want %0d", m2s_retired, exp_ret); end
    endtask

    task automatic test_flush();
        m1s_to_m2s_valid = 1'b1; m1s_to_m2s_bus = mk(1'b0, 4'hF, 1'b1, 5'd20, 32'hE, 32'h200);
        tick();
        m1s_to_m2s_bus = mk(1'b1, 4'hF, 1'b1, 5'd21, 32'hF, 32'h204);
        flush = 1'b1;
        #1;
        n_cmp++; if (m2s_to_ws_valid !== 1'b0) begin n_bad++; $display("FAIL flush_cycle_valid got %b want 0", m2s_to_ws_valid); end
        tick();
        flush = 1'b0; m1s_to_m2s_valid = 1'b0; m1s_to_m2s_bus = '0;
        #1;
        n_cmp++; if (m2s_to_ws_valid !== 1'b0 || m2s_allowin !== 1'b1) begin
            n_bad++; $display("FAIL flush_empty got valid=%b allowin=%b want 0/1", m2s_to_ws_valid, m2s_allowin);
        end
        n_cmp++; if (m2s_retired !== exp_ret) begin n_bad++; $display("FAIL flush_retired got %0d want %0d", m2s_retired, exp_ret); end
    endtask

    task automatic test_cancel();
        logic [74:0] g, gexp, h;
        g    = mk(1'b0, 4'hF, 1'b1, 5'd7, 32'h7777, 32'h300);
        gexp = mk(1'b0, 4'h0, 1'b0, 5'd7, 32'h7777, 32'h300);
        h    = mk(1'b1, 4'hF, 1'b1, 5'd9, 32'h9999, 32'h304);
        m1s_to_m2s_valid = 1'b1; m1s_to_m2s_bus = g;
        tick();
        m1s_to_m2s_valid = 1'b0; m1s_to_m2s_bus = '0; pair_cancel = 1'b1;
        #1;
        n_cmp++; if (m2s_to_ws_valid !== 1'b1 || m2s_to_ws_bus !== gexp) begin
            n_bad++; $display("FAIL cancel_bus got %b/%h want 1/%h", m2s_to_ws_valid, m2s_to_ws_bus, gexp);
        end
        n_cmp++; if (m2s_reg_write !== 1'b0) begin n_bad++; $display("FAIL cancel_regwrite got %b want 0", m2s_reg_write); end
        tick();
        pair_cancel = 1'b0;
        n_cmp++; if (m2s_retired !== exp_ret) begin n_bad++; $display("FAIL cancel_retired got %0d want %0d", m2s_retired, exp_ret); end
        m1s_to_m2s_valid = 1'b1; m1s_to_m2s_bus = h;
        tick();
        m1s_to_m2s_valid = 1'b0; m1s_to_m2s_bus = '0; pair_cancel = 1'b1;
        #1;
        n_cmp++; if (m2s_to_ws_bus !== h || m2s_reg_write !== 1'b1) begin
            n_bad++; $display("FAIL cancel_first got %h/%b want %h/1", m2s_to_ws_bus, m2s_reg_write, h);
        end
        tick();
        pair_cancel = 1'b0;
        exp_ret = exp_ret + 1;
        n_cmp++; if (m2s_retired !== exp_ret) begin n_bad++; $display("FAIL cancel_first_retired got %0d want %0d", m2s_retired, exp_ret); end
    endtask

    task automatic test_reset_mid_stall();
        m1s_to_m2s_valid = 1'b1; m1s_to_m2s_bus = mk(1'b0, 4'h5, 1'b1, 5'd17, 32'h5555, 32'h400);
        tick();
        m1s_to_m2s_valid = 1'b0; m1s_to_m2s_bus = '0; ws_allowin = 1'b0;
        tick();
        n_cmp++; if (m2s_to_ws_valid !== 1'b1 || m2s_allowin !== 1'b0) begin
            n_bad++; $display("FAIL midstall_pre got %b/%b want 1/0", m2s_to_ws_valid, m2s_allowin);
        end
        #2;
        resetn = 1'b0;
        #1;
        n_cmp++; if (m2s_to_ws_valid !== 1'b0 || m2s_reg_write !== 1'b0 || m2s_allowin !== 1'b1) begin
            n_bad++; $display("FAIL async_reset_ctl got v=%b rw=%b al=%b want 0/0/1", m2s_to_ws_valid, m2s_reg_write, m2s_allowin);
        end
        n_cmp++; if (m2s_rd !== 5'd0 || m2s_result !== 32'd0 || m2s_retired !== 32'd0) begin
            n_bad++; $display("FAIL async_reset_data got rd=%0d res=%h ret=%0d want 0/0/0", m2s_rd, m2s_result, m2s_retired);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_flush();
        test_cancel();
        test_reset_mid_stall();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
